// File: rtl/pkt_fifo_rd_ctrl_if.sv
// Handshake bundle between the packet FIFO read controller and its FIFO, ACL parser and AXIS sink.
// The master modport is the controller's view; slave is the surrounding environment.
interface pkt_fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_wr_tlast;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  i_fifo_last;
  logic                  i_fifo_empty;
  logic                  o_rd_valid;
  logic                  o_fifo_invalid;
  logic                  o_hdr_valid;
  logic [DATA_WIDTH-1:0] o_hdr_data;
  logic [2:0]            o_hdr_idx;
  logic                  i_verdict_valid;
  logic                  i_verdict_permit;
  logic                  o_tx_tvalid;
  logic [DATA_WIDTH-1:0] o_tx_tdata;
  logic                  o_tx_tlast;
  logic                  i_tx_tready;
  logic [3:0]            o_frame_cnt;
  logic [15:0]           o_drop_cnt;
  logic                  o_overflow;
  logic                  o_busy;

  modport master (
    input  i_wr_tlast, i_fifo_data, i_fifo_last, i_fifo_empty,
    input  i_verdict_valid, i_verdict_permit, i_tx_tready,
    output o_rd_valid, o_fifo_invalid, o_hdr_valid, o_hdr_data, o_hdr_idx,
    output o_tx_tvalid, o_tx_tdata, o_tx_tlast,
    output o_frame_cnt, o_drop_cnt, o_overflow, o_busy
  );

  modport slave (
    output i_wr_tlast, i_fifo_data, i_fifo_last, i_fifo_empty,
    output i_verdict_valid, i_verdict_permit, i_tx_tready,
    input  o_rd_valid, o_fifo_invalid, o_hdr_valid, o_hdr_data, o_hdr_idx,
    input  o_tx_tvalid, o_tx_tdata, o_tx_tlast,
    input  o_frame_cnt, o_drop_cnt, o_overflow, o_busy
  );
endinterface

// File: rtl/pkt_fifo_rd_ctrl.sv
// Packet FIFO read controller: feeds frame headers to an ACL parser, then forwards
// permitted frames on AXIS or flushes denied / timed-out frames from the FIFO.
module pkt_fifo_rd_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int HDR_WORDS       = 4,
  parameter int MAX_FRAMES      = 15,
  parameter int VERDICT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  pkt_fifo_rd_ctrl_if.master    bus
);

  localparam int              TMO_W    = $clog2(VERDICT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VERDICT_TIMEOUT - 1);
  localparam logic [2:0]      HDR_LAST = 3'(HDR_WORDS - 1);

  typedef enum logic [2:0] {IDLE, HDR, WAIT_V, FWD_HDR, FWD_BODY, DROP} state_t;

  state_t                  state_r;
  logic [2:0]              hdr_idx_r;
  logic [2:0]              tx_idx_r;
  logic                    ended_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic [3:0]              frame_cnt_r;
  logic [15:0]             drop_cnt_r;
  logic                    overflow_r;
  logic [DATA_WIDTH-1:0]   hdr_buf_r [8];

  logic                    rd_valid_s;
  logic                    fifo_invalid_s;
  logic                    hdr_valid_s;
  logic [DATA_WIDTH-1:0]   hdr_data_s;
  logic [2:0]              hdr_idx_s;
  logic                    tx_tvalid_s;
  logic [DATA_WIDTH-1:0]   tx_tdata_s;
  logic                    tx_tlast_s;
  logic                    pop_last_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-state output decode; pops are gated by FIFO occupancy so an empty FIFO is never read.
  always_comb begin
    rd_valid_s     = 1'b0;
    fifo_invalid_s = 1'b0;
    hdr_valid_s    = 1'b0;
    hdr_data_s     = '0;
    hdr_idx_s      = 3'd0;
    tx_tvalid_s    = 1'b0;
    tx_tdata_s     = '0;
    tx_tlast_s     = 1'b0;
    case (state_r)
      HDR: begin
        rd_valid_s  = !bus.i_fifo_empty;
        hdr_valid_s = !bus.i_fifo_empty;
        hdr_data_s  = bus.i_fifo_data;
        hdr_idx_s   = hdr_idx_r;
      end
      FWD_HDR: begin
        tx_tvalid_s = 1'b1;
        tx_tdata_s  = hdr_buf_r[tx_idx_r];
        tx_tlast_s  = ended_r && (tx_idx_r == HDR_LAST);
      end
      FWD_BODY: begin
        tx_tvalid_s = !bus.i_fifo_empty;
        tx_tdata_s  = bus.i_fifo_data;
        tx_tlast_s  = bus.i_fifo_last;
        rd_valid_s  = !bus.i_fifo_empty && bus.i_tx_tready;
      end
      DROP: begin
        rd_valid_s     = !bus.i_fifo_empty;
        fifo_invalid_s = 1'b1;
      end
      default: begin
        rd_valid_s = 1'b0;
      end
    endcase
  end

  assign pop_last_s = rd_valid_s && bus.i_fifo_last;

  // Frame sequencing FSM with header capture, verdict timeout and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hdr_idx_r  <= 3'd0;
      tx_idx_r   <= 3'd0;
      ended_r    <= 1'b0;
      tmo_cnt_r  <= '0;
      drop_cnt_r <= 16'd0;
      for (int i = 0; i < 8; i++) hdr_buf_r[i] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_cnt_r != 4'd0 && !bus.i_fifo_empty) begin
            state_r   <= HDR;
            hdr_idx_r <= 3'd0;
          end
        end
        HDR: begin
          if (!bus.i_fifo_empty) begin
            hdr_buf_r[hdr_idx_r] <= bus.i_fifo_data;
            if (hdr_idx_r == HDR_LAST) begin
              state_r   <= WAIT_V;
              ended_r   <= bus.i_fifo_last;
              tmo_cnt_r <= '0;
            end else if (bus.i_fifo_last) begin
              state_r    <= IDLE;
              drop_cnt_r <= sat_inc16(drop_cnt_r);
            end else begin
              hdr_idx_r <= hdr_idx_r + 3'd1;
            end
          end
        end
        WAIT_V: begin
          // A verdict arriving on the timeout cycle wins over the implicit deny.
          if (bus.i_verdict_valid && bus.i_verdict_permit) begin
            state_r  <= FWD_HDR;
            tx_idx_r <= 3'd0;
          end else if (bus.i_verdict_valid || tmo_cnt_r == TMO_LAST) begin
            state_r    <= ended_r ? IDLE : DROP;
            drop_cnt_r <= sat_inc16(drop_cnt_r);
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        FWD_HDR: begin
          if (bus.i_tx_tready) begin
            if (tx_idx_r == HDR_LAST) begin
              state_r <= ended_r ? IDLE : FWD_BODY;
            end else begin
              tx_idx_r <= tx_idx_r + 3'd1;
            end
          end
        end
        FWD_BODY, DROP: begin
          if (pop_last_s) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Committed-frame counter: a commit and a frame-end pop in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 4'd0;
      overflow_r  <= 1'b0;
    end else if (bus.i_wr_tlast && !pop_last_s) begin
      if (frame_cnt_r == 4'(MAX_FRAMES)) begin
        overflow_r <= 1'b1;
      end else begin
        frame_cnt_r <= frame_cnt_r + 4'd1;
      end
    end else if (pop_last_s && !bus.i_wr_tlast && frame_cnt_r != 4'd0) begin
      frame_cnt_r <= frame_cnt_r - 4'd1;
    end
  end

  assign bus.o_rd_valid     = rd_valid_s;
  assign bus.o_fifo_invalid = fifo_invalid_s;
  assign bus.o_hdr_valid    = hdr_valid_s;
  assign bus.o_hdr_data     = hdr_data_s;
  assign bus.o_hdr_idx      = hdr_idx_s;
  assign bus.o_tx_tvalid    = tx_tvalid_s;
  assign bus.o_tx_tdata     = tx_tdata_s;
  assign bus.o_tx_tlast     = tx_tlast_s;
  assign bus.o_frame_cnt    = frame_cnt_r;
  assign bus.o_drop_cnt     = drop_cnt_r;
  assign bus.o_overflow     = overflow_r;
  assign bus.o_busy         = (state_r != IDLE);

endmodule

// File: tb/tb_pkt_fifo_rd_ctrl.sv
// Scoreboard bench for pkt_fifo_rd_ctrl: a queue FIFO model feeds frames, expected header
// words and tx beats are queued per frame, and a negedge monitor pops and compares them.
module tb_pkt_fifo_rd_ctrl;
  localparam int DW  = 32;
  localparam int H   = 4;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  pkt_fifo_rd_ctrl #(
    .DATA_WIDTH(DW), .HDR_WORDS(H), .MAX_FRAMES(15), .VERDICT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW:0]   fifo_q[$];
  logic [DW+2:0] exp_hdr_q[$];
  logic [DW:0]   exp_tx_q[$];
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int m_drop = 0;
  bit pop_pend = 1'b0;
  int hdr_seen = 0, exp_hdr_n = 0, tx_beats = 0, inv_pops = 0, exp_inv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    logic [DW:0] h;
    if (fifo_q.size() == 0) begin
      bus.i_fifo_empty = 1'b1;
      bus.i_fifo_data  = '0;
      bus.i_fifo_last  = 1'b0;
    end else begin
      h = fifo_q[0];
      bus.i_fifo_empty = 1'b0;
      bus.i_fifo_data  = h[DW-1:0];
      bus.i_fifo_last  = h[DW];
    end
  endtask

  // One clock: apply the pop seen by the monitor, clear pulses, present the new FIFO head.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    bus.i_wr_tlast       = 1'b0;
    bus.i_verdict_valid  = 1'b0;
    bus.i_verdict_permit = 1'b0;
    refresh();
    #1;
  endtask

  // Reference: mode 0 permit, 1 deny, 2 timeout. Runts never reach a verdict.
  task automatic push_frame(input int len, input int mode);
    logic [DW-1:0] w;
    int nh;
    hdr_seen = 0; inv_pops = 0; tx_beats = 0;
    nh = (len < H) ? len : H;
    exp_hdr_n = nh;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      fifo_q.push_back({(i == len - 1), w});
      if (i < nh) exp_hdr_q.push_back({3'(i), w});
      if (len >= H && mode == 0) exp_tx_q.push_back({(i == len - 1), w});
    end
    if (len < H || mode != 0) m_drop++;
    exp_inv = (len > H && mode != 0) ? len - H : 0;
    bus.i_wr_tlast = 1'b1;
    refresh();
  endtask

  task automatic process_frame(input int mode, input int vdelay, input int tmode,
                               input int coincide_len, input int rst_beats);
    int n;
    bit tr;
    bit pushed_b;
    pushed_b = 1'b0;
    n = 0;
    while (!bus.o_busy && n < 20) begin step(); n++; end
    chk("start_busy", bus.o_busy, 1);
    n = 0;
    while (bus.o_busy && hdr_seen < exp_hdr_n && n < 50) begin
      if (tmode == 2) begin
        bus.i_verdict_valid  = ($urandom_range(0, 3) == 0);
        bus.i_verdict_permit = $urandom_range(0, 1);
      end
      step(); n++;
    end
    if (bus.o_busy) begin
      if (mode == 2) begin
        n = 0;
        while (bus.o_busy && !bus.o_fifo_invalid && n < 400) begin step(); n++; end
        chk("timeout_cycles", n, TMO);
      end else begin
        for (int k = 1; k < vdelay; k++) step();
        bus.i_verdict_valid  = 1'b1;
        bus.i_verdict_permit = (mode == 0);
        step();
      end
    end
    n = 0; tr = 1'b1;
    while (bus.o_busy && n < 2000) begin
      if (tmode == 1) begin
        bus.i_tx_tready = tr; tr = !tr;
      end else if (tmode == 2) begin
        bus.i_tx_tready      = $urandom_range(0, 1);
        bus.i_verdict_valid  = ($urandom_range(0, 4) == 0);
        bus.i_verdict_permit = $urandom_range(0, 1);
      end else begin
        bus.i_tx_tready = 1'b1;
      end
      #1;
      if (coincide_len > 0 && bus.o_rd_valid && bus.i_fifo_last) begin
        push_frame(coincide_len, 0);
        coincide_len = 0;
        pushed_b = 1'b1;
      end
      if (rst_beats > 0 && tx_beats >= rst_beats) begin
        rst = 1'b1;
        #1;
        chk("rst_ctrl", {bus.o_rd_valid, bus.o_fifo_invalid, bus.o_hdr_valid, bus.o_tx_tvalid,
                         bus.o_tx_tlast, bus.o_overflow, bus.o_busy}, 0);
        chk("rst_hdr", {bus.o_hdr_idx, bus.o_hdr_data}, 0);
        chk("rst_tdata", bus.o_tx_tdata, 0);
        chk("rst_cnts", {bus.o_frame_cnt, bus.o_drop_cnt}, 0);
        fifo_q.delete(); exp_hdr_q.delete(); exp_tx_q.delete();
        m_drop = 0;
        bus.i_tx_tready = 1'b0;
        refresh();
        step(); step();
        rst = 1'b0;
        return;
      end
      step(); n++;
    end
    bus.i_tx_tready = 1'b0;
    chk("frame_end_idle", bus.o_busy, 0);
    chk("drop_cnt", bus.o_drop_cnt, m_drop);
    chk("drop_pops", inv_pops, exp_inv);
    if (!pushed_b) begin
      chk("tx_left", exp_tx_q.size(), 0);
      chk("hdr_left", exp_hdr_q.size(), 0);
    end
  endtask

  // Monitor: compares every header word and tx beat, stall stability and the frame-count rule.
  initial begin : monitor
    logic [DW+2:0] eh;
    logic [DW:0]   et;
    logic [DW:0]   prev_beat;
    bit            prev_stall;
    bit            inc, dec;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cnt = 0; m_ovf = 1'b0; pop_pend = 1'b0; prev_stall = 1'b0;
      end else begin
        chk("frame_cnt", bus.o_frame_cnt, m_cnt);
        chk("overflow", bus.o_overflow, m_ovf);
        if (bus.o_rd_valid) chk("rd_while_empty", bus.i_fifo_empty, 0);
        if (bus.o_fifo_invalid) chk("tx_in_drop", bus.o_tx_tvalid, 0);
        if (bus.o_hdr_valid) begin
          if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 1, 0);
          else begin
            eh = exp_hdr_q.pop_front();
            chk("hdr_word", {bus.o_hdr_idx, bus.o_hdr_data}, eh);
          end
          hdr_seen++;
        end
        if (prev_stall) begin
          chk("stall_tvalid", bus.o_tx_tvalid, 1);
          chk("stall_beat", {bus.o_tx_tlast, bus.o_tx_tdata}, prev_beat);
        end
        if (bus.o_tx_tvalid && bus.i_tx_tready) begin
          if (exp_tx_q.size() == 0) chk("tx_unexpected", 1, 0);
          else begin
            et = exp_tx_q.pop_front();
            chk("tx_beat", {bus.o_tx_tlast, bus.o_tx_tdata}, et);
          end
          tx_beats++;
        end
        if (bus.o_tx_tvalid && !bus.i_tx_tready) chk("stall_no_pop", bus.o_rd_valid, 0);
        prev_stall = bus.o_tx_tvalid && !bus.i_tx_tready;
        prev_beat  = {bus.o_tx_tlast, bus.o_tx_tdata};
        if (bus.o_rd_valid && bus.o_fifo_invalid) inv_pops++;
        inc = bus.i_wr_tlast;
        dec = bus.o_rd_valid && bus.i_fifo_last;
        if (inc && !dec) begin
          if (m_cnt == 15) m_ovf = 1'b1;
          else m_cnt++;
        end else if (dec && !inc && m_cnt > 0) begin
          m_cnt--;
        end
        pop_pend = bus.o_rd_valid;
      end
    end
  end

  initial begin : stim
    int len, r, mode;
    rst = 1'b1;
    bus.i_wr_tlast = 1'b0; bus.i_verdict_valid = 1'b0; bus.i_verdict_permit = 1'b0;
    bus.i_tx_tready = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", {bus.o_rd_valid, bus.o_fifo_invalid, bus.o_hdr_valid, bus.o_tx_tvalid,
                       bus.o_overflow, bus.o_busy}, 0);
    chk("reset_cnts", {bus.o_frame_cnt, bus.o_drop_cnt}, 0);
    rst = 1'b0;
    step();

    push_frame(16, 0); process_frame(0, 3, 0, 0, 0);   // permit, verdict on 3rd wait cycle
    push_frame(16, 1); process_frame(1, 3, 0, 0, 0);   // deny: 12 flushed pops
    push_frame(16, 2); process_frame(2, 1, 2, 0, 0);   // verdict timeout
    push_frame(16, 0); process_frame(0, 2, 1, 0, 0);   // tready 1,0,1,0 backpressure
    push_frame(2, 0);  process_frame(0, 1, 0, 0, 0);   // runt
    push_frame(4, 0);  process_frame(0, 2, 0, 0, 0);   // frame ends in header
    push_frame(4, 1);  process_frame(1, 1, 0, 0, 0);   // header-only frame denied
    push_frame(8, 0);  process_frame(0, 2, 0, 6, 0);   // commit coincident with last pop
    process_frame(0, 2, 0, 0, 0);

    repeat (24) begin
      len  = $urandom_range(1, 20);
      r    = $urandom_range(0, 7);
      mode = (r < 5) ? 0 : ((r < 7) ? 1 : 2);
      push_frame(len, mode);
      process_frame(mode, $urandom_range(1, 6), 2, 0, 0);
    end

    for (int i = 0; i < 16; i++) begin
      bus.i_wr_tlast = 1'b1;
      step();
    end
    chk("ovf_cnt", bus.o_frame_cnt, 15);
    chk("ovf_flag", bus.o_overflow, 1);

    push_frame(16, 0); process_frame(0, 2, 0, 0, 8);   // reset mid FWD_BODY
    repeat (5) step();
    chk("post_rst_idle", bus.o_busy, 0);
    chk("post_rst_cnt", bus.o_frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_rd_ctrl.md
PKT_FIFO_RD_CTRL -- requirements
Module: pkt_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of FIFO read data and AXIS tx data.
REQ-002 SHALL have parameter HDR_WORDS, default 4, number of header words sent to the ACL parser per frame (range 1-8).
REQ-003 SHALL have parameter MAX_FRAMES, default 15, frame-counter ceiling; counter width 4.
REQ-004 SHALL have parameter VERDICT_TIMEOUT, default 255, cycles to wait for an ACL verdict.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 i_wr_tlast  in  1  one-cycle pulse: write side accepted a tlast word, so a full frame is committed in FIFO.
REQ-008 i_fifo_data  in  DATA_WIDTH  FIFO head word, first-word-fall-through, valid when i_fifo_empty=0.
REQ-009 i_fifo_last  in  1  tlast flag stored with the FIFO head word.
REQ-010 i_fifo_empty  in  1  FIFO empty.
REQ-011 o_rd_valid  out  1  pop strobe; head word consumed on the edge where it is 1.
REQ-012 o_fifo_invalid  out  1  high for every cycle of DROP.
REQ-013 o_hdr_valid / o_hdr_data / o_hdr_idx  out  1 / DATA_WIDTH / 3  header word to the parser with its index.
REQ-014 i_verdict_valid / i_verdict_permit  in  1 / 1  ACL verdict strobe and result, 1 = permit.
REQ-015 o_tx_tvalid / o_tx_tdata / o_tx_tlast  out  1 / DATA_WIDTH / 1  AXIS master output.
REQ-016 i_tx_tready  in  1  AXIS downstream ready.
REQ-017 o_frame_cnt  out  4  committed frames not yet fully read.
REQ-018 o_drop_cnt  out  16  frames dropped, saturating at 16'hFFFF.
REQ-019 o_overflow / o_busy  out  1 / 1  sticky frame-count overflow; state != IDLE.

Function
REQ-020 SHALL use FSM states IDLE, HDR, WAIT_V, FWD_HDR, FWD_BODY, DROP.
REQ-021 IDLE -> HDR when o_frame_cnt != 0 and i_fifo_empty=0; stay in IDLE otherwise.
REQ-022 HDR: each cycle with !i_fifo_empty, set o_rd_valid=1 and o_hdr_valid=1, present the head word with idx 0..HDR_WORDS-1, and store it in an internal header buffer.
REQ-023 HDR: after word HDR_WORDS-1 is popped with i_fifo_last=0 -> WAIT_V, timeout counter cleared.
REQ-024 HDR: if a popped word has i_fifo_last=1 before idx HDR_WORDS-1 (runt) -> IDLE, increment o_drop_cnt, no tx output; if idx HDR_WORDS-1 has last=1 -> WAIT_V and the frame end is remembered.
REQ-025 WAIT_V: i_verdict_valid with permit=1 -> FWD_HDR; with permit=0 -> DROP, or IDLE if the frame end was already consumed; count drop.
REQ-026 WAIT_V: timeout counter reaching VERDICT_TIMEOUT without a verdict SHALL be treated as deny.
REQ-027 Verdicts outside WAIT_V SHALL be ignored.
REQ-028 FWD_HDR: drive o_tx_tvalid=1 with buffer[k], advancing k on tvalid&tready; o_tx_tlast=1 only on the last buffered word of a frame ending in the header; after the final beat -> FWD_BODY, or IDLE if ended.
REQ-029 FWD_BODY: o_tx_tvalid = !i_fifo_empty, o_tx_tdata = i_fifo_data, o_tx_tlast = i_fifo_last, o_rd_valid = o_tx_tvalid & i_tx_tready; a popped last word -> IDLE.
REQ-030 tdata/tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-031 DROP: o_rd_valid = !i_fifo_empty, no tx output; a popped last word -> IDLE.
REQ-032 o_frame_cnt: +1 on i_wr_tlast, -1 on any pop with i_fifo_last=1, unchanged when both occur in the same cycle.
REQ-033 o_frame_cnt: an increment at MAX_FRAMES SHALL hold the value and set o_overflow; a decrement at 0 SHALL hold 0.
REQ-034 o_drop_cnt SHALL saturate at 16'hFFFF, not wrap.
REQ-035 o_rd_valid SHALL never be 1 while i_fifo_empty=1.

Reset
REQ-036 On rst, asynchronously: state IDLE; all outputs 0; counters, header buffer index, timeout counter and o_overflow cleared.
REQ-037 rst mid-frame SHALL abandon the frame without popping further words; after release, behaviour per REQ-021.

Verification
REQ-038 Permit: 16-word frame, i_wr_tlast pulse, verdict permit on 3rd WAIT_V cycle, tready=1 -> 4 hdr words idx 0-3, then 16 tx beats matching input, tlast on beat 16, o_frame_cnt 1->0.
REQ-039 Deny: same frame, permit=0 -> 12 remaining pops with o_fifo_invalid=1, zero tx beats, o_drop_cnt=1.
REQ-040 Timeout: no verdict -> DROP entered exactly 255 cycles after WAIT_V entry; o_drop_cnt increments.
REQ-041 Backpressure: tready toggled 1,0,1,0 during FWD_BODY -> no pop and stable tdata on tready=0 cycles; byte-exact output.
REQ-042 Boundaries: 2-word runt -> drop with no tx; i_wr_tlast coincident with last pop -> o_frame_cnt unchanged; 16 commits with no reads -> cnt=15, o_overflow=1.
REQ-043 Reset during FWD_BODY -> all outputs 0 same cycle, state IDLE, counters 0.
